// File: rtl/sram_arb_pkg.sv
// Shared types and default sizing for the SRAM write-path arbiter.
// The optional watchdog lives in sram_wr_arbiter and is enabled by ARB_WATCHDOG_EN.
package sram_arb_pkg;
  localparam int ARB_PORT_NUM   = 16;
  localparam int ARB_DATA_WIDTH = 16;
  localparam int ARB_LEN_WIDTH  = 12;

  typedef logic [$clog2(ARB_PORT_NUM)-1:0] port_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;
endpackage

// File: rtl/sram_wr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: the first set req strictly after rr_ptr
// (wrapping at PORT_NUM) wins, so the last-served port becomes lowest priority.
module rr_pick #(
  parameter  int PORT_NUM = 16,
  localparam int IDX_W    = $clog2(PORT_NUM)
) (
  input  logic [PORT_NUM-1:0] req,
  input  logic [IDX_W-1:0]    rr_ptr,
  output logic [IDX_W-1:0]    sel,
  output logic                any
);
  logic [IDX_W-1:0] idx;

  always_comb begin
    sel = '0;
    idx = '0;
    any = |req;
    // Walk the offsets from farthest to nearest so the nearest hit overwrites the rest.
    for (int i = PORT_NUM; i >= 1; i--) begin
      idx = IDX_W'((int'(rr_ptr) + i) % PORT_NUM);
      if (req[idx]) sel = idx;
    end
  end
endmodule

// File: rtl/sram_wr_arbiter.sv
// Round-robin packet arbiter in front of the page-based SRAM write interface.
// Optional macro ARB_WATCHDOG_EN aborts a granted packet after TIMEOUT idle cycles.
module sram_wr_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int PORT_NUM   = ARB_PORT_NUM,
  parameter  int DATA_WIDTH = ARB_DATA_WIDTH,
  parameter  int LEN_WIDTH  = ARB_LEN_WIDTH,
  parameter  int TIMEOUT    = 255,
  localparam int IDX_W      = $clog2(PORT_NUM)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sram_rdy,
  input  logic [PORT_NUM-1:0]            req,
  input  logic [PORT_NUM-1:0]            in_vld,
  input  logic [PORT_NUM*DATA_WIDTH-1:0] in_data,
  input  logic [PORT_NUM-1:0]            in_eop,
  output logic [PORT_NUM-1:0]            grant,
  output logic                           xfer_data_vld,
  output logic [DATA_WIDTH-1:0]          xfer_data,
  output logic                           end_of_packet,
  output logic [IDX_W-1:0]               xfer_port,
  output logic                           pkt_done,
  output logic [LEN_WIDTH-1:0]           pkt_len,
  output state_t                         arb_state
);
  // Handshake: sram_rdy acts as "ready" for packet start only and is sampled in IDLE;
  // once granted, words flow on in_vld with no backpressure until in_eop (or abort).
`ifdef ARB_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t                state;
  logic [IDX_W-1:0]      rr_ptr;
  logic [LEN_WIDTH-1:0]  cnt;
  logic [LEN_WIDTH-1:0]  cnt_inc;
  logic [WD_W-1:0]       wd_cnt;
  logic                  wd_hit;
  logic [IDX_W-1:0]      pick_sel;
  logic                  pick_any;
  logic                  g_vld;
  logic                  g_eop;
  logic [DATA_WIDTH-1:0] g_data;

  rr_pick #(.PORT_NUM(PORT_NUM)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .sel    (pick_sel),
    .any    (pick_any)
  );

  assign g_vld = in_vld[xfer_port];
  assign g_eop = in_eop[xfer_port];

  always_comb begin
    g_data = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (IDX_W'(i) == xfer_port) g_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Length saturates at all-ones; words keep flowing regardless.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + LEN_WIDTH'(1);
  assign wd_hit  = WD_EN && !g_vld && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign arb_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= IDX_W'(PORT_NUM - 1);
      grant         <= '0;
      xfer_port     <= '0;
      xfer_data_vld <= 1'b0;
      xfer_data     <= '0;
      end_of_packet <= 1'b0;
      pkt_done      <= 1'b0;
      pkt_len       <= '0;
      cnt           <= '0;
      wd_cnt        <= '0;
    end else begin
      xfer_data_vld <= 1'b0;
      end_of_packet <= 1'b0;
      pkt_done      <= 1'b0;
      case (state)
        IDLE: begin
          if (sram_rdy && pick_any) begin
            grant     <= PORT_NUM'(1) << pick_sel;
            xfer_port <= pick_sel;
            cnt       <= '0;
            wd_cnt    <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (g_vld) begin
            xfer_data_vld <= 1'b1;
            xfer_data     <= g_data;
            cnt           <= cnt_inc;
            wd_cnt        <= '0;
            if (g_eop) begin
              end_of_packet <= 1'b1;
              pkt_done      <= 1'b1;
              pkt_len       <= cnt_inc;
              grant         <= '0;
              rr_ptr        <= xfer_port;
              state         <= IDLE;
            end
          end else if (wd_hit) begin
            // Forced close: no data word accompanies this end_of_packet.
            end_of_packet <= 1'b1;
            pkt_done      <= 1'b1;
            pkt_len       <= cnt;
            grant         <= '0;
            rr_ptr        <= xfer_port;
            state         <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_wr_arbiter.sv
// Directed bench for sram_wr_arbiter: scoreboard of forwarded words and packet lengths,
// plus in-line checks of grant order, latency, sram_rdy gating and the idle watchdog.
module tb_sram_wr_arbiter;
  import sram_arb_pkg::*;

  localparam int PN = 16;
  localparam int DW = 16;
  localparam int LW = 12;
  localparam int EW = 1 + 4 + DW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           sram_rdy;
  logic [PN-1:0]  req;
  logic [PN-1:0]  in_vld;
  logic [PN*DW-1:0] in_data;
  logic [PN-1:0]  in_eop;
  logic [PN-1:0]  grant;
  logic           xfer_data_vld;
  logic [DW-1:0]  xfer_data;
  logic           end_of_packet;
  logic [3:0]     xfer_port;
  logic           pkt_done;
  logic [LW-1:0]  pkt_len;
  state_t         arb_state;

  logic [EW-1:0]  exp_q[$];
  logic [LW-1:0]  len_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;

  sram_wr_arbiter #(.PORT_NUM(PN), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sram_rdy      (sram_rdy),
    .req           (req),
    .in_vld        (in_vld),
    .in_data       (in_data),
    .in_eop        (in_eop),
    .grant         (grant),
    .xfer_data_vld (xfer_data_vld),
    .xfer_data     (xfer_data),
    .end_of_packet (end_of_packet),
    .xfer_port     (xfer_port),
    .pkt_done      (pkt_done),
    .pkt_len       (pkt_len),
    .arb_state     (arb_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input int p);
    int n = 0;
    while (grant == '0 && n < 50) begin
      tick();
      n++;
    end
    chk("grant", 64'(grant), 64'(PN'(1) << p));
    chk("xfer_port", 64'(xfer_port), 64'(p));
  endtask

  task automatic drive_word(input int p, input logic [DW-1:0] d, input bit eop);
    in_vld[p] = 1'b1;
    in_data[p*DW +: DW] = d;
    in_eop[p] = eop;
    exp_q.push_back({eop, 4'(p), d});
    tick();
    in_vld[p] = 1'b0;
    in_eop[p] = 1'b0;
  endtask

  task automatic send_pkt(input int p, input int n, input logic [DW-1:0] base, input bit clr_req);
    len_q.push_back((n > 4095) ? LW'(4095) : LW'(n));
    for (int i = 0; i < n; i++) begin
      if (i == n - 1 && clr_req) req[p] = 1'b0;
      drive_word(p, base + DW'(i), i == n - 1);
    end
  endtask

  // scoreboard: every forwarded word must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && xfer_data_vld) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $error("FAIL unexpected_word observed=%0h port=%0d expected=none", xfer_data, xfer_port);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk("word", 64'({end_of_packet, xfer_port, xfer_data}), 64'(e));
        chk("done_with_eop", 64'(pkt_done), 64'(end_of_packet));
        if (end_of_packet) begin
          logic [LW-1:0] l;
          l = (len_q.size() != 0) ? len_q.pop_front() : LW'(0);
          chk("pkt_len", 64'(pkt_len), 64'(l));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; sram_rdy = 1'b1; req = '0; in_vld = '0; in_data = '0; in_eop = '0;
    repeat (3) tick();
    chk("reset_outs", 64'({grant, xfer_data_vld, xfer_data, end_of_packet, xfer_port, pkt_done, pkt_len}), 64'(0));
    chk("reset_state", 64'(arb_state), 64'(IDLE));
    rst_n = 1'b1;

    // quiet after reset, then port 0 granted one cycle after its request
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_zero", 64'({grant, xfer_data_vld, xfer_data, end_of_packet, xfer_port, pkt_done, pkt_len}), 64'(0));
    end
    req[0] = 1'b1;
    tick();
    chk("first_grant", 64'(grant), 64'(1));
    send_pkt(0, 1, 16'h0100, 1'b1);
    tick();

    // full contention from fresh reset: strict rotation 0..15 then 0 again
    do_reset();
    req = '1;
    for (int k = 0; k <= 16; k++) begin
      wait_grant(k % 16);
      if (k == 16) req = 16'h0001;
      send_pkt(k % 16, 3, DW'(16'h1000 + k * 16), k == 16);
    end
    tick();
    chk("rotation_quiet", 64'(grant), 64'(0));

    // port 5 packet while non-granted port 6 chatters
    req[5] = 1'b1;
    wait_grant(5);
    len_q.push_back(LW'(8));
    for (int i = 0; i < 8; i++) begin
      in_vld[6] = i[0];
      in_data[6*DW +: DW] = DW'($urandom_range(0, 16'hFFFF));
      in_eop[6] = (i == 3);
      if (i == 7) req[5] = 1'b0;
      drive_word(5, DW'(16'hA001 + i), i == 7);
      chk("latency", 64'({xfer_data_vld, xfer_port, xfer_data}), 64'({1'b1, 4'd5, DW'(16'hA001 + i)}));
    end
    in_vld[6] = 1'b0; in_eop[6] = 1'b0;
    tick();

    // sram_rdy low holds off any grant
    sram_rdy = 1'b0;
    req[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rdy_hold", 64'(grant), 64'(0));
    end
    sram_rdy = 1'b1;
    tick();
    chk("rdy_grant", 64'(grant), 64'(PN'(1) << 2));
    send_pkt(2, 2, 16'h2200, 1'b1);
    tick();

    // single-word packet
    req[3] = 1'b1;
    wait_grant(3);
    send_pkt(3, 1, 16'h3333, 1'b1);
    chk("single_word", 64'({xfer_data_vld, end_of_packet, pkt_done, pkt_len}), 64'({1'b1, 1'b1, 1'b1, LW'(1)}));
    tick();

    // stalled packet on port 1
    req[1] = 1'b1;
    wait_grant(1);
    drive_word(1, 16'h1111, 1'b0);
    req[1] = 1'b0;
    drive_word(1, 16'h1112, 1'b0);
`ifdef ARB_WATCHDOG_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wd_early", 64'(end_of_packet), 64'(0));
    end
    tick();
    chk("wd_abort", 64'({end_of_packet, xfer_data_vld, pkt_done, pkt_len, grant}),
        64'({1'b1, 1'b0, 1'b1, LW'(2), PN'(0)}));
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("stall_hold", 64'({grant, end_of_packet}), 64'({PN'(1) << 1, 1'b0}));
    end
    len_q.push_back(LW'(3));
    drive_word(1, 16'h1113, 1'b1);
`endif
    tick();

    // length saturation
    req[7] = 1'b1;
    wait_grant(7);
    len_q.push_back(LW'(4095));
    for (int i = 0; i < 4100; i++) begin
      if (i == 4099) req[7] = 1'b0;
      drive_word(7, DW'($urandom_range(0, 16'hFFFF)), i == 4099);
    end
    chk("sat_len", 64'({end_of_packet, pkt_len}), 64'({1'b1, LW'(4095)}));

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick();
    chk("drain_words", 64'(exp_q.size()), 64'(0));
    chk("drain_lens", 64'(len_q.size()), 64'(0));
    chk("end_idle", 64'({grant, arb_state}), 64'({PN'(0), IDLE}));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
